// File: rtl/udp_frame_tx.sv
// udp_frame_tx: builds Ethernet II / IPv4 / UDP frames on a byte stream.
// A 42-byte header (with IPv4 header checksum) is followed by a pass-through
// payload of the requested length and zero padding up to a 60-byte frame.
module udp_frame_tx #(
    parameter logic [15:0] MAX_PAYLOAD = 16'd1472,
    parameter logic [7:0]  IP_TTL      = 8'd64
) (
    input  logic        tx_clk,
    input  logic        rst,
    input  logic        start_valid,
    output logic        start_ready,
    input  logic [15:0] start_len,
    input  logic [47:0] cfg_src_mac,
    input  logic [47:0] cfg_dst_mac,
    input  logic [31:0] cfg_src_ip,
    input  logic [31:0] cfg_dst_ip,
    input  logic [15:0] cfg_src_port,
    input  logic [15:0] cfg_dst_port,
    input  logic [7:0]  s_tdata,
    input  logic        s_tvalid,
    input  logic        s_tlast,
    output logic        s_tready,
    output logic [7:0]  m_tdata,
    output logic        m_tvalid,
    output logic        m_tlast,
    output logic        m_tuser,
    input  logic        m_tready,
    output logic        err,
    output logic [15:0] ip_id
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CSUM1 = 3'd1;
    localparam logic [2:0] S_CSUM2 = 3'd2;
    localparam logic [2:0] S_HDR   = 3'd3;
    localparam logic [2:0] S_PAY   = 3'd4;
    localparam logic [2:0] S_PAD   = 3'd5;

    localparam logic [15:0] MIN_PAYLOAD = 16'd18;

    // Control state
    logic [2:0]  state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [5:0]  hdr_idx_q, hdr_idx_d;
    logic [15:0] ip_id_q, ip_id_d;
    logic        err_q, err_d;

    // Datapath registers (no reset needed; written before use)
    logic [15:0] len_q;
    logic [19:0] sum_q;
    logic [15:0] csum_q;

    logic [15:0]  tot_len;
    logic [15:0]  udp_len;
    logic [335:0] hdr_vec;
    logic [5:0]   hdr_rev;
    logic [7:0]   hdr_byte;
    logic         len_bad;
    logic         pay_last;

    // Unfolded 20-bit sum of the ten IPv4 header words
    function automatic logic [19:0] ip_hdr_sum(input logic [15:0] tot,
                                               input logic [15:0] id,
                                               input logic [31:0] sip,
                                               input logic [31:0] dip);
        logic [19:0] s;
        s = 20'h04500 + {4'h0, tot} + {4'h0, id} + 20'h04000
          + {4'h0, IP_TTL, 8'h11} + 20'h00000
          + {4'h0, sip[31:16]} + {4'h0, sip[15:0]}
          + {4'h0, dip[31:16]} + {4'h0, dip[15:0]};
        return s;
    endfunction

    // One's-complement fold of the carries, then invert
    function automatic logic [15:0] csum_fold(input logic [19:0] s);
        logic [16:0] t;
        t = {1'b0, s[15:0]} + {13'h0000, s[19:16]};
        t = {1'b0, t[15:0]} + {16'h0000, t[16]};
        return ~t[15:0];
    endfunction

    assign tot_len  = len_q + 16'd28;
    assign udp_len  = len_q + 16'd8;
    assign len_bad  = (start_len == 16'd0) || (start_len > MAX_PAYLOAD);
    assign pay_last = (cnt_q == 16'd1);

    assign hdr_vec = {cfg_dst_mac, cfg_src_mac, 16'h0800,
                      16'h4500, tot_len, ip_id_q, 16'h4000, IP_TTL, 8'h11,
                      csum_q, cfg_src_ip, cfg_dst_ip,
                      cfg_src_port, cfg_dst_port, udp_len, 16'h0000};
    assign hdr_rev  = 6'd41 - hdr_idx_q;
    assign hdr_byte = hdr_vec[{hdr_rev, 3'b000} +: 8];

    assign start_ready = (state_q == S_IDLE);
    assign err         = err_q;
    assign ip_id       = ip_id_q;

    // Stream outputs: header/pad generated here, payload passes straight through
    always_comb begin
        m_tdata  = 8'h00;
        m_tvalid = 1'b0;
        m_tlast  = 1'b0;
        m_tuser  = 1'b0;
        s_tready = 1'b0;
        case (state_q)
            S_HDR: begin
                m_tvalid = 1'b1;
                m_tdata  = hdr_byte;
            end
            S_PAY: begin
                m_tdata  = s_tdata;
                m_tvalid = s_tvalid;
                s_tready = m_tready;
                m_tlast  = s_tvalid & (pay_last ? (len_q >= MIN_PAYLOAD) : s_tlast);
                m_tuser  = s_tvalid & ~pay_last & s_tlast;
            end
            S_PAD: begin
                m_tvalid = 1'b1;
                m_tlast  = pay_last;
            end
            default: ;
        endcase
    end

    // Next-state logic for the frame sequencer
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hdr_idx_d = hdr_idx_q;
        ip_id_d   = ip_id_q;
        err_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_valid) begin
                    if (len_bad) err_d   = 1'b1;
                    else         state_d = S_CSUM1;
                end
            end
            S_CSUM1: state_d = S_CSUM2;
            S_CSUM2: begin
                state_d   = S_HDR;
                hdr_idx_d = 6'd0;
            end
            S_HDR: begin
                if (m_tready) begin
                    if (hdr_idx_q == 6'd41) begin
                        state_d = S_PAY;
                        cnt_d   = len_q;
                    end else begin
                        hdr_idx_d = hdr_idx_q + 6'd1;
                    end
                end
            end
            S_PAY: begin
                if (s_tvalid && m_tready) begin
                    if (pay_last) begin
                        if (len_q >= MIN_PAYLOAD) begin
                            state_d = S_IDLE;
                            ip_id_d = ip_id_q + 16'd1;
                        end else begin
                            state_d = S_PAD;
                            cnt_d   = MIN_PAYLOAD - len_q;
                        end
                    end else if (s_tlast) begin
                        state_d = S_IDLE;
                        err_d   = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 16'd1;
                    end
                end
            end
            S_PAD: begin
                if (m_tready) begin
                    if (pay_last) begin
                        state_d = S_IDLE;
                        ip_id_d = ip_id_q + 16'd1;
                    end else begin
                        cnt_d = cnt_q - 16'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control registers with asynchronous reset
    always_ff @(posedge tx_clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= 16'd0;
            hdr_idx_q <= 6'd0;
            ip_id_q   <= 16'd0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hdr_idx_q <= hdr_idx_d;
            ip_id_q   <= ip_id_d;
            err_q     <= err_d;
        end
    end

    // Length latch and two-stage checksum pipeline
    always_ff @(posedge tx_clk) begin
        if (state_q == S_IDLE && start_valid) len_q <= start_len;
        if (state_q == S_CSUM1) sum_q  <= ip_hdr_sum(tot_len, ip_id_q, cfg_src_ip, cfg_dst_ip);
        if (state_q == S_CSUM2) csum_q <= csum_fold(sum_q);
    end

endmodule

// File: tb/tb_udp_frame_tx.sv
// Testbench for udp_frame_tx: table of frame requests with hand-computed
// header fields, checked byte-for-byte, plus a reset-during-header sequence.
module tb_udp_frame_tx;

    localparam logic [47:0] SRC_MAC = 48'h02_11_22_33_44_55;
    localparam logic [47:0] DST_MAC = 48'hFF_EE_DD_CC_BB_AA;
    localparam logic [31:0] SRC_IP  = 32'hC0A8010A;
    localparam logic [31:0] DST_IP  = 32'hC0A80101;
    localparam logic [15:0] SPORT   = 16'h1234;
    localparam logic [15:0] DPORT   = 16'h5678;

    logic        tx_clk = 1'b0;
    logic        rst;
    logic        start_valid;
    logic        start_ready;
    logic [15:0] start_len;
    logic [7:0]  s_tdata;
    logic        s_tvalid;
    logic        s_tlast;
    logic        s_tready;
    logic [7:0]  m_tdata;
    logic        m_tvalid;
    logic        m_tlast;
    logic        m_tuser;
    logic        m_tready;
    logic        err;
    logic [15:0] ip_id;

    udp_frame_tx dut (
        .tx_clk(tx_clk), .rst(rst),
        .start_valid(start_valid), .start_ready(start_ready), .start_len(start_len),
        .cfg_src_mac(SRC_MAC), .cfg_dst_mac(DST_MAC),
        .cfg_src_ip(SRC_IP), .cfg_dst_ip(DST_IP),
        .cfg_src_port(SPORT), .cfg_dst_port(DPORT),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tuser(m_tuser),
        .m_tready(m_tready), .err(err), .ip_id(ip_id)
    );

    always #5 tx_clk = ~tx_clk;

    typedef struct {
        logic [15:0] len;
        bit          thr;
        int          ulast;
        int          nerr;
        int          nbytes;
        logic [15:0] totlen;
        logic [15:0] csum;
        logic [15:0] ipid;
    } rec_t;

    rec_t vec [0:7];
    int total = 0;
    int bad = 0;
    int model_id = 0;
    logic [7:0] expf [0:1599];
    logic [7:0] gotf [0:1599];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_rec(input rec_t r);
        logic [335:0] h;
        logic [7:0]   prev_data;
        int plen, n, cyc, errs, extra, stab_bad, tuser_bad, mism, pidx, limit, lim;
        bit pend, done, prev_stall, last_user, sr_ok;
        plen = (r.ulast != 0) ? r.ulast : int'(r.len);
        h = {DST_MAC, SRC_MAC, 16'h0800, 16'h4500, r.totlen, 16'(model_id),
             16'h4000, 8'd64, 8'h11, r.csum, SRC_IP, DST_IP, SPORT, DPORT,
             r.len + 16'd8, 16'h0000};
        for (int i = 0; i < 42; i++) expf[i] = h[8*(41-i) +: 8];
        for (int i = 0; i < plen && i < 1500; i++) expf[42+i] = 8'(i);
        for (int i = 42 + plen; i < r.nbytes; i++) expf[i] = 8'h00;
        n = 0; cyc = 0; errs = 0; extra = 0; stab_bad = 0; tuser_bad = 0; mism = 0;
        pidx = 0; pend = 0; done = 0; prev_stall = 0; last_user = 0; prev_data = 8'h00;
        sr_ok = 1;

        @(negedge tx_clk);
        start_valid = 1'b1;
        start_len   = r.len;
        #1 chk("start_ready", 32'(start_ready), 32'd1);
        @(negedge tx_clk);
        start_valid = 1'b0;
        limit = (r.nbytes == 0) ? 8 : 20000;
        while (!done && cyc < limit) begin
            if (r.thr) begin
                m_tready = ($urandom_range(0, 3) != 0);
                if (!pend) pend = ($urandom_range(0, 1) != 0);
            end else begin
                m_tready = 1'b1;
                pend = 1'b1;
            end
            s_tvalid = pend && (pidx < plen);
            s_tdata  = 8'(pidx);
            s_tlast  = (r.ulast != 0) && (pidx + 1 == r.ulast);
            #1;
            if (err) errs++;
            if (prev_stall && !(m_tvalid && m_tdata == prev_data)) stab_bad++;
            prev_stall = m_tvalid && !m_tready;
            prev_data  = m_tdata;
            if (m_tvalid && m_tready) begin
                if (n < 1600) gotf[n] = m_tdata;
                if (m_tuser && !m_tlast) tuser_bad++;
                if (m_tlast) begin
                    done = 1;
                    last_user = m_tuser;
                end
                n++;
            end
            if (s_tvalid && s_tready) begin
                pidx++;
                pend = 0;
            end
            cyc++;
            @(negedge tx_clk);
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        m_tready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            if (err) errs++;
            if (m_tvalid) extra++;
            if (k > 0 && !start_ready) sr_ok = 0;
            @(negedge tx_clk);
        end

        if (r.nbytes != 0) chk("frame_done", 32'(done), 32'd1);
        chk("nbytes", 32'(n), 32'(r.nbytes));
        chk("err_pulses", 32'(errs), 32'(r.nerr));
        chk("extra_valid", 32'(extra), 32'd0);
        chk("idle_ready", 32'(sr_ok), 32'd1);
        if (r.nbytes != 0 && n >= 42) begin
            lim = (n < r.nbytes) ? n : r.nbytes;
            for (int i = 0; i < lim && i < 1600; i++) begin
                if (gotf[i] !== expf[i]) begin
                    if (mism == 0)
                        $display("FAIL byte %0d: got %0h expected %0h", i, gotf[i], expf[i]);
                    mism++;
                end
            end
            chk("bytes", 32'(mism), 32'd0);
            chk("totlen", 32'({gotf[16], gotf[17]}), 32'(r.totlen));
            chk("csum", 32'({gotf[24], gotf[25]}), 32'(r.csum));
            chk("udp_len", 32'({gotf[38], gotf[39]}), 32'(r.len + 16'd8));
            chk("stable", 32'(stab_bad), 32'd0);
            chk("tuser_mid", 32'(tuser_bad), 32'd0);
            chk("tuser_end", 32'(last_user), 32'(r.ulast != 0));
        end
        chk("ip_id", 32'(ip_id), 32'(r.ipid));
        if (r.nbytes != 0 && r.ulast == 0) model_id++;
    endtask

    initial begin
        int cnt;
        //         len      thr   ulast err nbytes totlen    csum       ipid after
        vec[0] = '{16'd18,   1'b0, 0,  0, 60,   16'h002E, 16'hB763, 16'd1};
        vec[1] = '{16'd4,    1'b0, 0,  0, 60,   16'h0020, 16'hB770, 16'd2};
        vec[2] = '{16'd0,    1'b0, 0,  1, 0,    16'h0000, 16'h0000, 16'd2};
        vec[3] = '{16'd1473, 1'b0, 0,  1, 0,    16'h0000, 16'h0000, 16'd2};
        vec[4] = '{16'd1472, 1'b1, 0,  0, 1514, 16'h05DC, 16'hB1B3, 16'd3};
        vec[5] = '{16'd17,   1'b1, 0,  0, 60,   16'h002D, 16'hB761, 16'd4};
        vec[6] = '{16'd100,  1'b0, 50, 1, 92,   16'h0080, 16'hB70D, 16'd4};
        vec[7] = '{16'd46,   1'b1, 0,  0, 88,   16'h004A, 16'hB743, 16'd5};

        rst = 1'b1;
        start_valid = 1'b0;
        start_len = 16'd0;
        s_tdata = 8'h00;
        s_tvalid = 1'b0;
        s_tlast = 1'b0;
        m_tready = 1'b1;
        repeat (2) @(negedge tx_clk);
        #1;
        chk("rst_m_tvalid", 32'(m_tvalid), 32'd0);
        chk("rst_s_tready", 32'(s_tready), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_ip_id", 32'(ip_id), 32'd0);
        chk("rst_start_ready", 32'(start_ready), 32'd1);
        @(negedge tx_clk);
        rst = 1'b0;

        for (int v = 0; v < 8; v++) run_rec(vec[v]);

        // Reset asserted in the middle of the header
        @(negedge tx_clk);
        m_tready = 1'b1;
        start_valid = 1'b1;
        start_len = 16'd20;
        @(negedge tx_clk);
        start_valid = 1'b0;
        cnt = 0;
        for (int c = 0; c < 40 && cnt < 10; c++) begin
            #1;
            if (m_tvalid && m_tready) cnt++;
            @(negedge tx_clk);
        end
        chk("hdr_reached", 32'(cnt), 32'd10);
        #2 rst = 1'b1;
        #1;
        chk("midrst_m_tvalid", 32'(m_tvalid), 32'd0);
        chk("midrst_start_ready", 32'(start_ready), 32'd1);
        chk("midrst_s_tready", 32'(s_tready), 32'd0);
        chk("midrst_ip_id", 32'(ip_id), 32'd0);
        @(negedge tx_clk);
        rst = 1'b0;
        model_id = 0;
        run_rec(vec[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
